// File: rtl/dmem_store_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_store_buffer_if
// Description : Core-side store/load handshake and data-memory port bundle
//               for the posted-store buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_store_buffer_if;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_sel;
    logic        st_ready;

    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [2:0]  ld_sel;
    logic        ld_stall;

    logic        empty;

    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_dataW;
    logic [1:0]  mem_store_sel;

    modport master (
        output st_valid, st_addr, st_data, st_sel,
        input  st_ready,
        output ld_valid, ld_addr, ld_sel,
        input  ld_stall, empty,
        input  mem_wr_en, mem_addr, mem_dataW, mem_store_sel
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_sel,
        output st_ready,
        input  ld_valid, ld_addr, ld_sel,
        output ld_stall, empty,
        output mem_wr_en, mem_addr, mem_dataW, mem_store_sel
    );
endinterface
`default_nettype wire

// File: rtl/dmem_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : dmem_store_buffer
// Description : In-order posted-store queue that drains to data memory when
//               no load owns the port; stalls loads overlapping pending stores.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_store_buffer #(
    parameter int DEPTH = 4
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    dmem_store_buffer_if.slave  bus
);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    localparam logic [1:0] c_STORE_SEL_B = 2'd0;
    localparam logic [1:0] c_STORE_SEL_H = 2'd1;
    localparam logic [1:0] c_STORE_SEL_W = 2'd2;

    localparam logic [2:0] c_LOAD_SEL_B  = 3'd0;
    localparam logic [2:0] c_LOAD_SEL_BU = 3'd1;
    localparam logic [2:0] c_LOAD_SEL_H  = 3'd2;
    localparam logic [2:0] c_LOAD_SEL_HU = 3'd3;
    localparam logic [2:0] c_LOAD_SEL_W  = 3'd4;

    localparam logic c_MEM_WRITE = 1'b1;

    function automatic logic [2:0] store_size(input logic [1:0] sel);
        case (sel)
            c_STORE_SEL_B: return 3'd1;
            c_STORE_SEL_H: return 3'd2;
            c_STORE_SEL_W: return 3'd4;
            default:       return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] load_size(input logic [2:0] sel);
        case (sel)
            c_LOAD_SEL_B, c_LOAD_SEL_BU: return 3'd1;
            c_LOAD_SEL_H, c_LOAD_SEL_HU: return 3'd2;
            c_LOAD_SEL_W:                return 3'd4;
            default:                     return 3'd0;
        endcase
    endfunction

    // Range ends are 33 bits wide so accesses near 2^32 never alias low addresses.
    function automatic logic ranges_overlap(
        input logic [31:0] a, input logic [2:0] sa,
        input logic [31:0] b, input logic [2:0] sb
    );
        logic [32:0] a_end;
        logic [32:0] b_end;
        a_end = {1'b0, a} + {30'd0, sa};
        b_end = {1'b0, b} + {30'd0, sb};
        return (sa != 3'd0) && (sb != 3'd0) &&
               ({1'b0, a} < b_end) && ({1'b0, b} < a_end);
    endfunction

    logic [31:0]        r_addr [DEPTH];
    logic [31:0]        r_data [DEPTH];
    logic [1:0]         r_sel  [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic [DEPTH-1:0]   w_hit;
    logic [2:0]         w_ld_size;
    logic               w_stall;
    logic               w_drain;
    logic               w_ready;
    logic               w_enq;

    assign w_ld_size = load_size(bus.ld_sel);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [c_PTR_W-1:0] w_off;
        // Slot is live when its distance from head is below the occupancy.
        assign w_off     = c_PTR_W'(gi) - r_head;
        assign w_hit[gi] = ({1'b0, w_off} < r_count) &&
                           ranges_overlap(bus.ld_addr, w_ld_size,
                                          r_addr[gi], store_size(r_sel[gi]));
    end

    assign w_stall = bus.ld_valid && (|w_hit);
    assign w_drain = (r_count != '0) && !(bus.ld_valid && !w_stall);
    assign w_ready = (r_count < c_DEPTH);
    assign w_enq   = bus.st_valid && w_ready;

    assign bus.st_ready      = w_ready;
    assign bus.ld_stall      = w_stall;
    assign bus.empty         = (r_count == '0);
    assign bus.mem_wr_en     = w_drain ? c_MEM_WRITE : ~c_MEM_WRITE;
    assign bus.mem_addr      = w_drain ? r_addr[r_head] : bus.ld_addr;
    assign bus.mem_dataW     = w_drain ? r_data[r_head] : 32'd0;
    assign bus.mem_store_sel = r_sel[r_head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + c_PTR_W'(1);
            end
            if (w_drain) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            case ({w_enq, w_drain})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_tail] <= bus.st_addr;
            r_data[r_tail] <= bus.st_data;
            r_sel[r_tail]  <= bus.st_sel;
        end
    end
endmodule
`default_nettype wire
